// File: rtl/mul_seq_ctrl.sv
// Shift-add sequencer for a 32x32->64 unsigned multiply. It drives an external 32-bit adder for one pass per cycle.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip the iteration loop and finish in one cycle.
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_ready,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product,
    output logic [WIDTH-1:0]   o_add_a,
    output logic [WIDTH-1:0]   o_add_b,
    output logic               o_add_cin,
    input  logic [WIDTH-1:0]   i_add_result,
    input  logic               i_add_cout
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [5:0]       r_cnt;

    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Adder B is forced to zero outside RUN, so the adder stays quiet while idle.
    assign o_add_a   = r_hi;
    assign o_add_b   = (r_state == S_RUN && r_lo[0]) ? r_mcand : '0;
    assign o_add_cin = 1'b0;

    // Shift the sum right by one. The carry enters the top of hi, and the bit that drops out enters lo.
    assign w_hi_nxt = {i_add_cout, i_add_result[WIDTH-1:1]};
    assign w_lo_nxt = {i_add_result[0], r_lo[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            o_ready   <= 1'b1;
            o_done    <= 1'b0;
            o_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_lo    <= i_b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        o_ready <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
                        if (i_a == '0 || i_b == '0) begin
                            r_state   <= S_DONE;
                            o_done    <= 1'b1;
                            o_product <= '0;
                        end else begin
                            r_state <= S_RUN;
                        end
`else
                        r_state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST) begin
                        r_state   <= S_DONE;
                        o_done    <= 1'b1;
                        o_product <= {w_hi_nxt, w_lo_nxt};
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
